// File: rtl/alu_arbiter_ctrl.sv
// Two-requester arbiter and sequencer for a shared ALU with LAT-cycle latency.
// Macro ALU_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.
module alu_arbiter_ctrl #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_start,
    input  logic [N-1:0] alu_y,
    input  logic [1:0]   alu_flags,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_y,
    output logic [1:0]   rsp_flags,
    output logic         rsp_err,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

    localparam logic [2:0] LAT_CNT = 3'(LAT);
    localparam logic [2:0] OP_MAX  = 3'b100;

    state_e       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         id_q, id_d;
    logic [N-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]   alu_op_q, alu_op_d;
    logic         alu_start_q, alu_start_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_y_q, rsp_y_d;
    logic [1:0]   rsp_flags_q, rsp_flags_d;
    logic         rsp_err_q, rsp_err_d;

    logic         accept;
    logic         gnt;
    logic [2:0]   sel_op;
    logic [N-1:0] sel_a, sel_b;

    // NOTE: ready is gated with rst_n so it stays low while reset is held, even with valids high.
    assign accept = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);

`ifdef ALU_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    assign gnt          = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
    assign last_grant_d = accept ? gnt : last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
`else
    assign gnt = ~req0_valid;
`endif

    assign req0_ready = accept && !gnt;
    assign req1_ready = accept &&  gnt;
    assign sel_op     = gnt ? req1_op : req0_op;
    assign sel_a      = gnt ? req1_a  : req0_a;
    assign sel_b      = gnt ? req1_b  : req0_b;

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_start_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d = gnt;
                    if (sel_op <= OP_MAX) begin
                        state_d     = EXEC;
                        cnt_d       = LAT_CNT;
                        alu_a_d     = sel_a;
                        alu_b_d     = sel_b;
                        alu_op_d    = sel_op;
                        alu_start_d = 1'b1;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = gnt;
                        rsp_y_d     = '0;
                        rsp_flags_d = 2'b00;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 3'd1) begin
                    state_d     = RESP;
                    cnt_d       = 3'd0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_y_d     = alu_y;
                    rsp_flags_d = alu_flags;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                // Response fields return to zero together with rsp_valid.
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = 1'b0;
                    rsp_y_d     = '0;
                    rsp_flags_d = 2'b00;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            id_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 3'b000;
            alu_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_start_q <= alu_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_start = alu_start_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter_ctrl.md
ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n.
REQ-002 Parameter N, default 4: operand/result width in bits.
REQ-003 Parameter LAT, default 1: ALU latency in cycles, legal 1..7.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 reqK_valid  in  1  requester K (K=0,1) has an operation pending.
REQ-007 reqK_ready  out  1  requester K operation accepted this cycle.
REQ-008 reqK_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101..111 illegal.
REQ-009 reqK_a, reqK_b  in  N  operands.
REQ-010 alu_a, alu_b  out  N  registered operands to the shared ALU.
REQ-011 alu_op  out  3  registered opcode to the ALU.
REQ-012 alu_start  out  1  one-cycle ALU launch pulse.
REQ-013 alu_y  in  N  ALU result; alu_flags  in  2  {carry, zero}.
REQ-014 rsp_valid  out  1  response available; rsp_ready  in  1  consumer accepts.
REQ-015 rsp_id  out  1  index of the requester owning the response.
REQ-016 rsp_y  out  N; rsp_flags  out  2; rsp_err  out  1  illegal-opcode indication.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, EXEC, RESP; exactly one active; encoding free.
REQ-019 IDLE: if any reqK_valid, grant one requester, assert its reqK_ready combinationally that cycle only, register op/a/b/id at the edge.
REQ-020 At most one reqK_ready high per cycle; reqK_ready is 0 outside IDLE.
REQ-021 Legal opcode: IDLE -> EXEC; illegal opcode: IDLE -> RESP with rsp_err=1, rsp_y=0, rsp_flags=00, no alu_start.
REQ-022 alu_start high exactly in the first EXEC cycle; alu_a/alu_b/alu_op stable for all of EXEC.
REQ-023 EXEC lasts exactly LAT cycles (down-counter loaded with LAT); alu_y/alu_flags captured at the edge ending the LAT-th cycle; then -> RESP.
REQ-024 RESP: rsp_valid=1, rsp_id/rsp_y/rsp_flags/rsp_err held stable until the cycle rsp_valid & rsp_ready; then -> IDLE.
REQ-025 rsp_ready low holds RESP indefinitely (backpressure); no new grant while not IDLE.
REQ-026 Acceptance-to-rsp_valid latency LAT+1 cycles (legal op), 1 cycle (illegal op); minimum issue interval LAT+2 cycles.
REQ-027 reqK_valid dropping before grant is allowed; no grant is given to a requester whose valid is low.
REQ-028 Response outputs are 0 whenever rsp_valid is 0.

Reset
REQ-029 rst_n low forces immediately: state IDLE, all outputs 0, counter 0, last_grant=1.
REQ-030 Reset mid-EXEC or mid-RESP aborts the operation; no response is ever produced for it.
REQ-031 First grant possible on the first rising clk edge with rst_n high.

Configuration
REQ-032 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous valid, grant the requester not in last_grant; last_grant updates on every grant.
REQ-033 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; last_grant unused.

Verification
REQ-034 Reset, req0 AND a=4'hC b=4'hA, LAT=1, alu_y=4'h8 -> req0_ready 1 cycle, alu_start next cycle, rsp_valid 2 cycles after accept, rsp_y=8, rsp_id=0.
REQ-035 Both valid continuously, RR_EN defined -> grants 0,1,0,1; undefined -> grants 0,0,0,0.
REQ-036 req1 op=3'b110 -> no alu_start, rsp_valid 1 cycle after accept, rsp_err=1, rsp_y=0, rsp_id=1.
REQ-037 rsp_ready held low 5 cycles in RESP -> rsp_* stable, busy=1, both reqK_ready=0; rsp_ready high -> IDLE next cycle.
REQ-038 LAT=3, rst_n pulsed low during second EXEC cycle -> all outputs 0 immediately, no rsp_valid after release.
